aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
Controller that sequences the key-expansion engine (key_exp_outer) and serves its round keys to the cipher round datapath. It accepts a cipher key and mode over a load handshake and holds the expander in reset until a key is loaded. It then runs expansion, waits for the expander's ready signal and parks the expander. Per data block, it streams round keys over a valid/ready interface: ascending order for encryption, descending order for decryption.

Parameters:
TIMEOUT, 64, max cycles allowed in EXPAND before flagging an error (must be ≥ 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
key_in  in  256  cipher key; AES-128 uses [127:0]; AES-192 uses [191:0]
mode_in  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=illegal
key_load_valid  in  1  key load request
key_load_ready  out  1  controller accepts key load
kx_key  out  256  registered key to expander
kx_mode  out  2  registered mode to expander
kx_reset  out  1  expander reset; high=idle/park, low=run
kx_rkey_addr  out  4  expander key-memory read address
kx_rkey  in  128  expander read data, valid 1 cycle after address
kx_rdy  in  1  expander finished
blk_start  in  1  start round-key stream for one block (1-cycle pulse)
blk_decrypt  in  1  sampled with blk_start; 1=descending order
rk_valid  out  1  round key valid
rk_ready  in  1  consumer accepts round key
rk_data  out  128  round key
rk_round  out  4  round index of rk_data
rk_last  out  1  final key of the stream
key_valid  out  1  expanded key resident and usable
busy  out  1  state is not IDLE and not KEYREADY
err  out  1  sticky: illegal mode or expansion timeout; cleared by next accepted load

Behaviour:
- Nr from the latched mode: 00→10, 01→12, 10→14. Stream length is Nr+1 keys.
- Reset values: state=IDLE, kx_reset=1, kx_key=0, kx_mode=0, kx_rkey_addr=0, rk_valid=0, rk_data=0, rk_round=0, rk_last=0, key_valid=0, busy=0, err=0.
- States: IDLE, EXPAND, KEYREADY, FETCH, SERVE.
- key_load_ready=1 only in IDLE and KEYREADY. A load is accepted when key_load_valid && key_load_ready.
- On an accepted load, key_in and mode_in are latched into kx_key and kx_mode, err is cleared, and key_valid is cleared.
  - Legal mode: go to EXPAND.
  - Mode 11: set err=1, go to IDLE, and keep kx_reset=1.
- EXPAND:
  - kx_reset=0 and the watchdog counter increments each cycle.
  - When kx_rdy=1: drive kx_reset=1 on the next cycle, set key_valid=1, go to KEYREADY.
  - When the counter reaches TIMEOUT with no kx_rdy: set err=1, key_valid=0, kx_reset=1, go to IDLE.
  - The expander retains its key memory while kx_reset is high.
- KEYREADY:
  - blk_start latches blk_decrypt, sets kx_rkey_addr to 0 (encrypt) or Nr (decrypt), and goes to FETCH.
  - If blk_start and key_load_valid are both asserted in the same cycle, the load wins and blk_start is ignored.
- blk_start is ignored in every state except KEYREADY. In IDLE, a block start produces no stream.
- FETCH: lasts one cycle (read latency). Then go to SERVE with rk_data=kx_rkey, rk_round=current address, rk_valid=1, and rk_last=1 when the address equals the final address (Nr for encrypt, 0 for decrypt).
- SERVE:
  - rk_data, rk_round and rk_last stay stable while rk_valid && !rk_ready.
  - On handshake with rk_last=0: rk_valid=0, address ±1, go to FETCH.
  - On handshake with rk_last=1: rk_valid=0, go to KEYREADY.
  - Throughput is one key per 2 cycles at best.
- key_load_valid is not accepted during EXPAND, FETCH or SERVE (ready stays low).
- Address stays within 0..Nr and never wraps.
- reset asserted in any state, mid-stream included, restores all reset values on the next clock edge. An in-flight rk_valid drops and key_valid=0, so the key must be reloaded.

Test Plan:
- AES-128 load of key 2b7e151628aed2a6abf7158809cf4f3c with kx_rdy after 20 cycles → key_valid=1. Encrypt block → 11 keys, round 0 = the key itself, round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
- Same key, decrypt → first key rk_round=10 = d014f9a8…, last key rk_round=0 with rk_last=1. rk_ready held low for 5 cycles mid-stream → outputs stable.
- AES-256 (mode 10) → 15 keys, rk_round 0..14, kx_rkey_addr never exceeds 14. AES-192 → 13 keys.
- mode_in=11 load → err=1, key_valid=0, kx_reset stays 1. Subsequent legal load → err clears.
- kx_rdy never asserts → err=1 after 64 EXPAND cycles, state IDLE. blk_start then yields no rk_valid.
- reset pulsed during SERVE of round 5 → next cycle rk_valid=0, key_valid=0, kx_reset=1. Simultaneous blk_start+key_load_valid in KEYREADY → load accepted, no stream.

Source files
------------

// File: rtl/aes_key_sched_ctrl_if.sv
// Round-key stream bundle between the key schedule controller
// and the cipher round datapath.
interface aes_key_sched_ctrl_if;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;

  modport master (
    output rk_valid,
    output rk_data,
    output rk_round,
    output rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid,
    input  rk_data,
    input  rk_round,
    input  rk_last,
    output rk_ready
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// Sequences the key expander and streams its round keys,
// ascending for encryption and descending for decryption.
module aes_key_sched_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [255:0]           key_in,
  input  logic [1:0]             mode_in,
  input  logic                   key_load_valid,
  output logic                   key_load_ready,
  output logic [255:0]           kx_key,
  output logic [1:0]             kx_mode,
  output logic                   kx_reset,
  output logic [3:0]             kx_rkey_addr,
  input  logic [127:0]           kx_rkey,
  input  logic                   kx_rdy,
  input  logic                   blk_start,
  input  logic                   blk_decrypt,
  aes_key_sched_ctrl_if.master   rk,
  output logic                   key_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    EXPAND,
    KEYREADY,
    FETCH,
    SERVE
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   key_d;
  logic [1:0]     mode_d;
  logic           kxrst_d;
  logic [3:0]     addr_d;
  logic           dec_q, dec_d;
  logic [CW-1:0]  wd_q, wd_d;
  logic           vld_d;
  logic [127:0]   data_d;
  logic [3:0]     round_d;
  logic           last_d;
  logic           kv_d;
  logic           err_d;
  logic [3:0]     nr;
  logic [3:0]     final_addr;
  logic           load_acc;

  always_comb begin
    nr = 4'd10;
    unique case (kx_mode)
      2'b01:   nr = 4'd12;
      2'b10:   nr = 4'd14;
      default: nr = 4'd10;
    endcase
  end

  assign final_addr     = dec_q ? 4'd0 : nr;
  assign key_load_ready = (state_q == IDLE) ||
                          (state_q == KEYREADY);
  assign load_acc       = key_load_valid && key_load_ready;
  assign busy           = !key_load_ready;

  always_comb begin
    state_d = state_q;
    key_d   = kx_key;
    mode_d  = kx_mode;
    kxrst_d = kx_reset;
    addr_d  = kx_rkey_addr;
    dec_d   = dec_q;
    wd_d    = wd_q;
    vld_d   = rk.rk_valid;
    data_d  = rk.rk_data;
    round_d = rk.rk_round;
    last_d  = rk.rk_last;
    kv_d    = key_valid;
    err_d   = err;
    unique case (state_q)
      IDLE, KEYREADY: begin
        // A load beats a simultaneous block start.
        if (load_acc) begin
          key_d  = key_in;
          mode_d = mode_in;
          err_d  = 1'b0;
          kv_d   = 1'b0;
          wd_d   = '0;
          if (mode_in == 2'b11) begin
            err_d   = 1'b1;
            kxrst_d = 1'b1;
            state_d = IDLE;
          end else begin
            kxrst_d = 1'b0;
            state_d = EXPAND;
          end
        end else if (state_q == KEYREADY && blk_start) begin
          dec_d   = blk_decrypt;
          addr_d  = blk_decrypt ? nr : 4'd0;
          state_d = FETCH;
        end
      end
      EXPAND: begin
        wd_d = wd_q + CW'(1);
        if (kx_rdy) begin
          kxrst_d = 1'b1;
          kv_d    = 1'b1;
          state_d = KEYREADY;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          kv_d    = 1'b0;
          kxrst_d = 1'b1;
          state_d = IDLE;
        end
      end
      FETCH: begin
        data_d  = kx_rkey;
        round_d = kx_rkey_addr;
        vld_d   = 1'b1;
        last_d  = (kx_rkey_addr == final_addr);
        state_d = SERVE;
      end
      SERVE: begin
        if (rk.rk_ready) begin
          vld_d = 1'b0;
          if (rk.rk_last) begin
            state_d = KEYREADY;
          end else begin
            addr_d  = dec_q ? kx_rkey_addr - 4'd1
                            : kx_rkey_addr + 4'd1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      kx_key       <= '0;
      kx_mode      <= '0;
      kx_reset     <= 1'b1;
      kx_rkey_addr <= '0;
      dec_q        <= 1'b0;
      wd_q         <= '0;
      rk.rk_valid  <= 1'b0;
      rk.rk_data   <= '0;
      rk.rk_round  <= '0;
      rk.rk_last   <= 1'b0;
      key_valid    <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      kx_key       <= key_d;
      kx_mode      <= mode_d;
      kx_reset     <= kxrst_d;
      kx_rkey_addr <= addr_d;
      dec_q        <= dec_d;
      wd_q         <= wd_d;
      rk.rk_valid  <= vld_d;
      rk.rk_data   <= data_d;
      rk.rk_round  <= round_d;
      rk.rk_last   <= last_d;
      key_valid    <= kv_d;
      err          <= err_d;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl with a table-driven
// round-key memory standing in for the expander.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_in;
  logic [1:0]   mode_in;
  logic         key_load_valid;
  logic         key_load_ready;
  logic [255:0] kx_key;
  logic [1:0]   kx_mode;
  logic         kx_reset;
  logic [3:0]   kx_rkey_addr;
  logic [127:0] kx_rkey;
  logic         kx_rdy;
  logic         blk_start;
  logic         blk_decrypt;
  logic         key_valid;
  logic         busy;
  logic         err;

  aes_key_sched_ctrl_if rk_bus ();

  aes_key_sched_ctrl #(.TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .key_in         (key_in),
    .mode_in        (mode_in),
    .key_load_valid (key_load_valid),
    .key_load_ready (key_load_ready),
    .kx_key         (kx_key),
    .kx_mode        (kx_mode),
    .kx_reset       (kx_reset),
    .kx_rkey_addr   (kx_rkey_addr),
    .kx_rkey        (kx_rkey),
    .kx_rdy         (kx_rdy),
    .blk_start      (blk_start),
    .blk_decrypt    (blk_decrypt),
    .rk             (rk_bus),
    .key_valid      (key_valid),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [16];
  assign kx_rkey = mem[kx_rkey_addr];

  localparam logic [255:0] KEY128 =
    {128'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [255:0] KEY256 =
    {128'h603deb1015ca71be2b73aef0857d7781,
     128'h1f352c073b6108d72d9810a30914dff4};

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [1:0] mode;
    logic       dec;
    int         nr;
    int         stall_at;
    int         stall_len;
    int         rdy;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [255:0] k,
                          input logic [1:0] m,
                          input int rdy);
    key_in         = k;
    mode_in        = m;
    key_load_valid = 1'b1;
    chk("load_ready", 256'(key_load_ready), 256'(1));
    tick;
    key_load_valid = 1'b0;
    chk("expand_busy", 256'(busy), 256'(1));
    chk("expand_kxrst", 256'(kx_reset), 256'(0));
    chk("expand_noready", 256'(key_load_ready), 256'(0));
    chk("kx_key", kx_key, k);
    repeat (rdy - 1) tick;
    kx_rdy = 1'b1;
    tick;
    kx_rdy = 1'b0;
    chk("key_valid", 256'(key_valid), 256'(1));
    chk("park_kxrst", 256'(kx_reset), 256'(1));
    chk("keyready_idle", 256'(busy), 256'(0));
  endtask

  task automatic run_stream(input logic dec, input int nr,
                            input int stall_at,
                            input int stall_len);
    int r;
    int w;
    blk_decrypt = dec;
    blk_start   = 1'b1;
    tick;
    blk_start   = 1'b0;
    chk("start_addr", 256'(kx_rkey_addr),
        256'(dec ? nr : 0));
    for (int k = 0; k <= nr; k++) begin
      r = dec ? nr - k : k;
      w = 0;
      while (!rk_bus.rk_valid && w < 6) begin
        tick;
        w++;
      end
      chk("rk_valid_wait", 256'(rk_bus.rk_valid), 256'(1));
      chk("rk_data", 256'(rk_bus.rk_data), 256'(mem[r]));
      chk("rk_round", 256'(rk_bus.rk_round), 256'(r));
      chk("rk_last", 256'(rk_bus.rk_last), 256'(k == nr));
      chk("addr_range", 256'(kx_rkey_addr <= 4'(nr)), 256'(1));
      chk("serve_noload", 256'(key_load_ready), 256'(0));
      if (k == stall_at) begin
        rk_bus.rk_ready = 1'b0;
        repeat (stall_len) begin
          tick;
          chk("stall_valid", 256'(rk_bus.rk_valid), 256'(1));
          chk("stall_data", 256'(rk_bus.rk_data),
              256'(mem[r]));
          chk("stall_round", 256'(rk_bus.rk_round), 256'(r));
          chk("stall_last", 256'(rk_bus.rk_last),
              256'(k == nr));
        end
        rk_bus.rk_ready = 1'b1;
      end
      tick;
      chk("rk_valid_drop", 256'(rk_bus.rk_valid), 256'(0));
    end
    chk("stream_done", 256'(busy), 256'(0));
  endtask

  initial begin
    int  w;
    logic seen;

    mem[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    mem[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    mem[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    mem[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    mem[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    mem[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    mem[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    mem[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    mem[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    mem[9]  = 128'hac7766f319fadc2128d12941575c006e;
    mem[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 11; i < 16; i++)
      mem[i] = {4{32'(i) * 32'h01010101}};

    vecs[0] = '{2'b00, 1'b0, 10, -1, 0, 20};
    vecs[1] = '{2'b00, 1'b1, 10,  4, 5, 3};
    vecs[2] = '{2'b10, 1'b0, 14, -1, 0, 5};
    vecs[3] = '{2'b01, 1'b0, 12, -1, 0, 2};
    vecs[4] = '{2'b01, 1'b1, 12,  6, 1, 1};
    vecs[5] = '{2'b10, 1'b1, 14,  0, 2, 7};

    reset           = 1'b1;
    key_in          = '0;
    mode_in         = '0;
    key_load_valid  = 1'b0;
    kx_rdy          = 1'b0;
    blk_start       = 1'b0;
    blk_decrypt     = 1'b0;
    rk_bus.rk_ready = 1'b1;
    tick;
    tick;
    chk("rst_kxrst", 256'(kx_reset), 256'(1));
    chk("rst_kxkey", kx_key, 256'(0));
    chk("rst_kxmode", 256'(kx_mode), 256'(0));
    chk("rst_addr", 256'(kx_rkey_addr), 256'(0));
    chk("rst_valid", 256'(rk_bus.rk_valid), 256'(0));
    chk("rst_data", 256'(rk_bus.rk_data), 256'(0));
    chk("rst_round", 256'(rk_bus.rk_round), 256'(0));
    chk("rst_last", 256'(rk_bus.rk_last), 256'(0));
    chk("rst_kv", 256'(key_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    reset = 1'b0;
    tick;

    for (int v = 0; v < 6; v++) begin
      load_key(KEY128, vecs[v].mode, vecs[v].rdy);
      chk("vec_mode", 256'(kx_mode), 256'(vecs[v].mode));
      run_stream(vecs[v].dec, vecs[v].nr,
                 vecs[v].stall_at, vecs[v].stall_len);
    end

    // Illegal mode from KEYREADY, then a legal reload.
    key_in         = KEY256;
    mode_in        = 2'b11;
    key_load_valid = 1'b1;
    tick;
    key_load_valid = 1'b0;
    chk("ill_err", 256'(err), 256'(1));
    chk("ill_kv", 256'(key_valid), 256'(0));
    chk("ill_kxrst", 256'(kx_reset), 256'(1));
    chk("ill_idle", 256'(busy), 256'(0));
    chk("ill_mode", 256'(kx_mode), 256'(3));
    tick;
    chk("ill_kxrst_hold", 256'(kx_reset), 256'(1));
    load_key(KEY128, 2'b00, 4);
    chk("reload_err_clr", 256'(err), 256'(0));

    // Load and block start together: load wins.
    key_in         = KEY256;
    mode_in        = 2'b01;
    key_load_valid = 1'b1;
    blk_start      = 1'b1;
    blk_decrypt    = 1'b0;
    tick;
    key_load_valid = 1'b0;
    blk_start      = 1'b0;
    chk("both_busy", 256'(busy), 256'(1));
    chk("both_kxrst", 256'(kx_reset), 256'(0));
    chk("both_kv", 256'(key_valid), 256'(0));
    chk("both_mode", 256'(kx_mode), 256'(1));
    seen = 1'b0;
    repeat (3) begin
      tick;
      if (rk_bus.rk_valid) seen = 1'b1;
    end
    chk("both_nostream", 256'(seen), 256'(0));
    kx_rdy = 1'b1;
    tick;
    kx_rdy = 1'b0;
    chk("both_kv_done", 256'(key_valid), 256'(1));

    // Reset while serving round 5.
    blk_decrypt = 1'b0;
    blk_start   = 1'b1;
    tick;
    blk_start   = 1'b0;
    w = 0;
    while (!(rk_bus.rk_valid && rk_bus.rk_round == 4'd5)
           && w < 30) begin
      tick;
      w++;
    end
    chk("r5_reached", 256'(rk_bus.rk_valid && rk_bus.rk_round == 4'd5),
        256'(1));
    rk_bus.rk_ready = 1'b0;
    reset = 1'b1;
    tick;
    chk("mid_rst_valid", 256'(rk_bus.rk_valid), 256'(0));
    chk("mid_rst_kv", 256'(key_valid), 256'(0));
    chk("mid_rst_kxrst", 256'(kx_reset), 256'(1));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_data", 256'(rk_bus.rk_data), 256'(0));
    chk("mid_rst_addr", 256'(kx_rkey_addr), 256'(0));
    reset = 1'b0;
    rk_bus.rk_ready = 1'b1;
    tick;

    // Expansion timeout with no kx_rdy.
    key_in         = KEY128;
    mode_in        = 2'b00;
    key_load_valid = 1'b1;
    tick;
    key_load_valid = 1'b0;
    repeat (63) tick;
    chk("to_err_early", 256'(err), 256'(0));
    chk("to_busy_early", 256'(busy), 256'(1));
    tick;
    chk("to_err", 256'(err), 256'(1));
    chk("to_idle", 256'(busy), 256'(0));
    chk("to_kxrst", 256'(kx_reset), 256'(1));
    chk("to_kv", 256'(key_valid), 256'(0));
    chk("to_ready", 256'(key_load_ready), 256'(1));
    blk_start = 1'b1;
    tick;
    blk_start = 1'b0;
    seen = rk_bus.rk_valid;
    repeat (4) begin
      tick;
      if (rk_bus.rk_valid) seen = 1'b1;
    end
    chk("idle_nostream", 256'(seen), 256'(0));
    chk("idle_err_sticky", 256'(err), 256'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
